alu74181_nibble_seq: RTL and testbench

// - Upstream driver for the 4-bit alu74181 slice: performs 4*NIBBLES-bit ops by sequencing the slice one nibble at a time, LSB first.
// - Registers operands, drives A/B/S/M/CNb, samples F/AEB/CN4b, ripples carry nibble to nibble, assembles the wide result.
// - The slice is combinational, on-chip or looped through IO pads; each nibble gets a drive cycle plus a sample cycle.

---
 rtl/alu74181_nibble_seq.sv | 146 ++++++++++++++
 tb/tb_alu74181_nibble_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu74181_nibble_seq.sv
// Sequences a combinational 4-bit 74181 slice over NIBBLES nibbles (LSB first) to build a 4*NIBBLES-bit op.
// Optional macro ALU_SEQ_SETTLE_EN inserts a WAIT state of SETTLE_CYCLES cycles between drive and sample.
module alu74181_nibble_seq #(
  parameter int NIBBLES       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic [3:0]           op_s,
  input  logic                 op_m,
  input  logic                 op_cnb,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out_b,
  output logic                 a_eq_b,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cnb,
  input  logic [3:0]           alu_f,
  input  logic                 alu_aeb,
  input  logic                 alu_cn4b
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES-1);

`ifdef ALU_SEQ_SETTLE_EN
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES-1 : 0);
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_SAMPLE, S_DONE} state_t;
  logic [CW-1:0] r_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;
`endif

  state_t        r_state, w_next;
  logic [W-1:0]  r_a, r_b, r_result;
  logic [3:0]    r_s, r_alu_a, r_alu_b, r_alu_s;
  logic          r_m, r_alu_m, r_alu_cnb;
  logic [IW-1:0] r_idx;
  logic          r_carry, r_aeb, r_busy, r_done, r_cout_b, r_a_eq_b;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DRIVE;
`ifdef ALU_SEQ_SETTLE_EN
      S_DRIVE:  w_next = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_WAIT;
      S_WAIT:   if (r_cnt == CNT_LAST) w_next = S_SAMPLE;
`else
      S_DRIVE:  w_next = S_SAMPLE;
`endif
      S_SAMPLE: w_next = (r_idx == IDX_LAST) ? S_DONE : S_DRIVE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_a       <= '0;
      r_b       <= '0;
      r_s       <= '0;
      r_m       <= 1'b0;
      r_idx     <= '0;
      r_carry   <= 1'b1;
      r_aeb     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_cout_b  <= 1'b1;
      r_a_eq_b  <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_s   <= '0;
      r_alu_m   <= 1'b0;
      r_alu_cnb <= 1'b1;
`ifdef ALU_SEQ_SETTLE_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_a     <= op_a;
          r_b     <= op_b;
          r_s     <= op_s;
          r_m     <= op_m;
          r_idx   <= '0;
          r_carry <= op_cnb;
          r_aeb   <= 1'b1;
          r_busy  <= 1'b1;
        end
        S_DRIVE: begin
          r_alu_a   <= r_a[4*r_idx +: 4];
          r_alu_b   <= r_b[4*r_idx +: 4];
          r_alu_s   <= r_s;
          r_alu_m   <= r_m;
          r_alu_cnb <= r_carry;
`ifdef ALU_SEQ_SETTLE_EN
          r_cnt     <= '0;
`endif
        end
`ifdef ALU_SEQ_SETTLE_EN
        S_WAIT: r_cnt <= r_cnt + CW'(1);
`endif
        S_SAMPLE: begin
          // Carry ripples even in logic mode; the slice ignores it there.
          r_result[4*r_idx +: 4] <= alu_f;
          r_carry <= alu_cn4b;
          r_aeb   <= r_aeb & alu_aeb;
          if (r_idx != IDX_LAST) r_idx <= r_idx + IW'(1);
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_cout_b <= r_carry;
          r_a_eq_b <= r_aeb;
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign carry_out_b = r_cout_b;
  assign a_eq_b      = r_a_eq_b;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_s       = r_alu_s;
  assign alu_m       = r_alu_m;
  assign alu_cnb     = r_alu_cnb;
endmodule

// File: tb/tb_alu74181_nibble_seq.sv
// Bench for alu74181_nibble_seq: behavioural 74181 slice on the ALU port, wide-arithmetic reference model.
module tb_alu74181_nibble_seq;
  localparam int N  = 4;
  localparam int W  = 4*N;
  localparam int ST = 2;
`ifdef ALU_SEQ_SETTLE_EN
  localparam int LAT = 2*N + N*ST + 1;
`else
  localparam int LAT = 2*N + 1;
`endif

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [3:0]   op_s = '0;
  logic         op_m = 1'b0, op_cnb = 1'b1;
  logic         busy, done, carry_out_b, a_eq_b, alu_m, alu_cnb, alu_aeb, alu_cn4b;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  int           n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu74181_nibble_seq #(.NIBBLES(N), .SETTLE_CYCLES(ST)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cnb(op_cnb),
    .busy(busy), .done(done), .result(result), .carry_out_b(carry_out_b), .a_eq_b(a_eq_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cnb(alu_cnb),
    .alu_f(alu_f), .alu_aeb(alu_aeb), .alu_cn4b(alu_cn4b));

  // 74181 (active-high data): F = P plus G plus carry, or ~(P^G) in logic mode.
  function automatic logic [5:0] slice181(input logic [3:0] a, b, s, input logic m, cnb);
    logic [3:0] p, g, f;
    logic [4:0] sum;
    p   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    g   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, p} + {1'b0, g} + {4'b0, ~cnb};
    f   = m ? ~(p ^ g) : sum[3:0];
    return {&f, ~sum[4], f};
  endfunction

  assign {alu_aeb, alu_cn4b, alu_f} = slice181(alu_a, alu_b, alu_s, alu_m, alu_cnb);

  // Reference for the whole wide op: {a_eq_b, carry_out_b, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, b, input logic [3:0] s,
                                          input logic m, cnb);
    logic [W-1:0] p, g, r;
    logic [W:0]   sum;
    p   = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    g   = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    sum = {1'b0, p} + {1'b0, g} + {{W{1'b0}}, ~cnb};
    r   = m ? ~(p ^ g) : sum[W-1:0];
    return {(r == {W{1'b1}}), ~sum[W], r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_coutb"}, 32'(carry_out_b), 1);
    check({tag, "_aeq"}, 32'(a_eq_b), 0);
    check({tag, "_alu_ab"}, 32'({alu_a, alu_b}), 0);
    check({tag, "_alu_smc"}, 32'({alu_s, alu_m, alu_cnb}), 32'h1);
  endtask

  task automatic launch(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cnb);
    op_a = a; op_b = b; op_s = s; op_m = m; op_cnb = cnb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 200);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, b, input logic [3:0] s,
                        input logic m, cnb);
    logic [W+1:0] e;
    int           cyc;
    e = ref_op(a, b, s, m, cnb);
    launch(a, b, s, m, cnb);
    check({tag, "_busy_on"}, 32'(busy), 1);
    wait_done(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_result"}, 32'(result), 32'(e[W-1:0]));
    check({tag, "_coutb"}, 32'(carry_out_b), 32'(e[W]));
    check({tag, "_aeq"}, 32'(a_eq_b), 32'(e[W+1]));
    check({tag, "_busy_off"}, 32'(busy), 0);
    check({tag, "_alu_hold"}, 32'({alu_a, alu_b, alu_s, alu_m}), 32'({a[W-1 -: 4], b[W-1 -: 4], s, m}));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin : main
    int           nd;
    logic [W+1:0] e;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("reset");

    run_op("t1_add", 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    check("t1_const", 32'({carry_out_b, result}), 32'h1_0100);
    run_op("t2_ovf", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    check("t2_const", 32'({carry_out_b, result}), 32'h0_0000);
    run_op("t3_sub_eq", 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1);
    check("t3_const", 32'({a_eq_b, result}), 32'h1_FFFF);
    run_op("t4_sub", 16'h1235, 16'h1234, 4'b0110, 1'b0, 1'b1);
    check("t4_const", 32'({a_eq_b, result}), 32'h0_0000);
    run_op("t5_xor", 16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b1);
    check("t5_const", 32'(result), 32'hAA55);

    // start during an op must be dropped
    e = ref_op(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1);
    launch(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 op_a = 16'h7777; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nd = 0;
    repeat (3*LAT) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        check("t6a_result", 32'(result), 32'(e[W-1:0]));
      end
    end
    check("t6a_done_count", 32'(nd), 1);

    // reset mid-op: no done, outputs back to reset values
    launch(16'h4321, 16'h1234, 4'b1001, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_vals("t6b_rst");
    nd = 0;
    repeat (2*LAT) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("t6b_no_done", 32'(nd), 0);
    run_op("t6b_after", 16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b0);

    // start together with reset is dropped
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    nd = 0;
    repeat (2*LAT) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    check("rst_start_dropped", 32'(nd), 0);

    for (int i = 0; i < 24; i++)
      run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 4'($urandom_range(15)),
             1'($urandom_range(1)), 1'($urandom_range(1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
